bt_uart_rx: RTL and testbench
=============================

Name: bt_uart_rx

Overview:
UART receive front end for the Bluetooth module serial link. Synchronises the raw fpga_rxd pin, frames 8N1 characters at a fixed baud divisor, and presents each byte on a valid/ready handshake to the FPGA_Bluetooth_connection datapath. Reception is gated by the module's bt_state (link-connected) line.

Parameters:
CLKS_PER_BIT, 5208, clock cycles per UART bit (50 MHz / 9600 baud); minimum 4
HALF_BIT, CLKS_PER_BIT/2 (integer divide), offset from detected start edge to the start-bit sample point

Ports:
clock  input  1  system clock; all logic on rising edge
resetn  input  1  asynchronous, active-low reset
fpga_rxd  input  1  raw serial line from the Bluetooth module; idle high
bt_state  input  1  Bluetooth link-connected flag; asynchronous
rx_ready  input  1  consumer can accept rx_data this cycle
rx_data  output  8  received byte, LSB first on the line
rx_valid  output  1  rx_data holds an unconsumed byte
rx_frame_err  output  1  one-cycle pulse: stop bit (or parity) bad
rx_overrun  output  1  one-cycle pulse: completed byte dropped, holding register full
rx_busy  output  1  FSM not in IDLE

Behaviour:
- Reset: rx_data=0x00, rx_valid=0, rx_frame_err=0, rx_overrun=0, rx_busy=0. Both synchronisers reset to 1 (rxd) and 0 (bt_state). FSM goes to IDLE, counters and shift register clear. Applies immediately on resetn low, mid-frame included.
- Synchronisation: fpga_rxd and bt_state each pass through 2 flops. All timing below is relative to the synchronised signals.
- FSM states: IDLE, START, DATA, STOP, WAIT_HIGH (plus PARITY if enabled).
- IDLE:
  - On cycle t0, where rxd_s=0 and bt_state_s=1, go to START with the bit counter at 0.
- Sample points are t0+HALF_BIT+k*CLKS_PER_BIT:
  - k=0: start bit.
  - k=1..8: data bits 0..7.
  - k=9: stop bit.
- START at its sample point:
  - rxd_s=0: go to DATA.
  - rxd_s=1: glitch; return to IDLE with no flags.
- DATA: shift each sample into bit[idx], LSB first. After idx 7, go to STOP.
- STOP at its sample point:
  - rxd_s=1: deliver the byte and go to IDLE.
  - rxd_s=0: pulse rx_frame_err, discard the byte, go to WAIT_HIGH.
- WAIT_HIGH: return to IDLE on the first cycle with rxd_s=1. A held-low break produces exactly one rx_frame_err.
- Delivery, in the cycle after the stop sample:
  - rx_valid=0, or rx_valid=1 with rx_ready=1: load rx_data, set rx_valid=1, no overrun.
  - rx_valid=1 and rx_ready=0: keep the old rx_data, pulse rx_overrun, drop the new byte.
- Handshake: the byte transfers on any cycle with rx_valid and rx_ready both high. rx_valid clears in the next cycle unless a simultaneous delivery reloads it. rx_data is stable while rx_valid=1.
- bt_state_s low while not IDLE: force IDLE next cycle, discard the partial byte, raise no flags. The holding register and rx_valid are unaffected.
- rx_busy: combinational, high whenever state != IDLE.
- Counters: bit counter ceil(log2(CLKS_PER_BIT)) bits, index counter 3 bits. The bit counter reloads to 0 at every sample point and never wraps otherwise.

Optional Feature:
Macro: BT_UART_RX_PARITY_EN.
- Defined: frame is 8E1. PARITY state samples at k=9 and the stop bit moves to k=10. Delivery requires the even-parity check to pass and stop=1. A parity mismatch with a good stop bit pulses rx_frame_err, discards the byte and goes to IDLE, not WAIT_HIGH.
- Undefined: 8N1 as above; no PARITY state is synthesised.

Test Plan (CLKS_PER_BIT=16, bt_state=1, rx_ready=1 unless stated):
1. Send 0xA5 8N1.
   -> rx_valid pulses one cycle with rx_data=0xA5, exactly HALF_BIT+9*16+1 = 153 clocks after the synchronised falling edge; rx_frame_err=0.
2. Drive fpga_rxd low for 4 clocks, then high.
   -> FSM returns to IDLE after the start sample; no rx_valid, no rx_frame_err; a following 0x3C is received correctly.
3. Send 0x3C with stop bit 0, hold low 40 clocks, then send 0x55.
   -> exactly one rx_frame_err pulse, no rx_valid for 0x3C; rx_data=0x55 with rx_valid afterwards.
4. rx_ready=0; send 0x11 then 0x22 back-to-back.
   -> rx_valid=1 and rx_data=0x11 held; rx_overrun pulses once at the 0x22 delivery; raising rx_ready clears rx_valid next cycle.
5. Deassert bt_state during data bit 3 of 0x77; reassert it; send 0x99.
   -> no flags or rx_valid for 0x77; 0x99 received correctly.
6. Assert resetn low during DATA with rx_valid=1.
   -> all outputs 0 immediately; after release, 0xF0 is received normally.
   -> Parity build additionally: 0x0F with a wrong parity bit gives rx_frame_err and no rx_valid.

Source files
------------

// File: rtl/bt_uart_rx.sv
// UART 8N1 receive front end for the Bluetooth serial link, gated by bt_state.
// Define BT_UART_RX_PARITY_EN to receive 8E1 frames with even-parity checking.
module bt_uart_rx #(
    parameter int unsigned CLKS_PER_BIT = 5208,
    parameter int unsigned HALF_BIT     = CLKS_PER_BIT / 2
) (
    input  logic       clock,
    input  logic       resetn,
    input  logic       fpga_rxd,
    input  logic       bt_state,
    input  logic       rx_ready,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_frame_err,
    output logic       rx_overrun,
    output logic       rx_busy
);

    localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_BIT - 1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef BT_UART_RX_PARITY_EN
        PARITY,
`endif
        STOP,
        WAIT_HIGH
    } rxState_t;

    rxState_t   state, stateNext;
    logic       rxdMeta, rxdS;
    logic       btMeta, btS;
    logic [CNT_W-1:0] bitCnt, cntNext;
    logic [2:0] bitIdx, idxNext;
    logic [7:0] shiftReg, shiftNext;
    logic       samplePt;
    logic       parityOk;
    logic       deliver;
    logic       frameErrNext;
    logic       overrunNext;
    logic       validNext;
    logic [7:0] dataNext;

`ifdef BT_UART_RX_PARITY_EN
    logic parBit, parNext;
    assign parityOk = ~(^{shiftReg, parBit});
`else
    assign parityOk = 1'b1;
`endif

    // Two-flop synchronisers; rxd idles high, link flag idles disconnected.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            rxdMeta <= 1'b1;
            rxdS    <= 1'b1;
            btMeta  <= 1'b0;
            btS     <= 1'b0;
        end else begin
            rxdMeta <= fpga_rxd;
            rxdS    <= rxdMeta;
            btMeta  <= bt_state;
            btS     <= btMeta;
        end
    end

    // Start bit is sampled half a bit after the edge, later bits a full bit apart.
    assign samplePt = (state == START) ? (bitCnt == HALF_LAST) : (bitCnt == BIT_LAST);

    always_comb begin
        stateNext    = state;
        cntNext      = samplePt ? '0 : bitCnt + 1'b1;
        idxNext      = bitIdx;
        shiftNext    = shiftReg;
        deliver      = 1'b0;
        frameErrNext = 1'b0;
`ifdef BT_UART_RX_PARITY_EN
        parNext      = parBit;
`endif
        case (state)
            IDLE: begin
                cntNext = '0;
                idxNext = '0;
                if (!rxdS && btS) begin
                    stateNext = START;
                    shiftNext = '0;
                end
            end
            START: begin
                if (samplePt) begin
                    stateNext = rxdS ? IDLE : DATA;
                end
            end
            DATA: begin
                if (samplePt) begin
                    shiftNext[bitIdx] = rxdS;
                    if (bitIdx == 3'd7) begin
                        idxNext = '0;
`ifdef BT_UART_RX_PARITY_EN
                        stateNext = PARITY;
`else
                        stateNext = STOP;
`endif
                    end else begin
                        idxNext = bitIdx + 3'd1;
                    end
                end
            end
`ifdef BT_UART_RX_PARITY_EN
            PARITY: begin
                if (samplePt) begin
                    parNext   = rxdS;
                    stateNext = STOP;
                end
            end
`endif
            STOP: begin
                if (samplePt) begin
                    if (rxdS && parityOk) begin
                        deliver   = 1'b1;
                        stateNext = IDLE;
                    end else if (rxdS) begin
                        frameErrNext = 1'b1;
                        stateNext    = IDLE;
                    end else begin
                        frameErrNext = 1'b1;
                        stateNext    = WAIT_HIGH;
                    end
                end
            end
            WAIT_HIGH: begin
                cntNext = '0;
                if (rxdS) begin
                    stateNext = IDLE;
                end
            end
            default: begin
                stateNext = IDLE;
                cntNext   = '0;
                idxNext   = '0;
            end
        endcase

        // Losing the link abandons any frame in progress silently.
        if (state != IDLE && !btS) begin
            stateNext    = IDLE;
            cntNext      = '0;
            idxNext      = '0;
            deliver      = 1'b0;
            frameErrNext = 1'b0;
        end
    end

    always_comb begin
        validNext   = rx_valid;
        dataNext    = rx_data;
        overrunNext = 1'b0;
        if (rx_valid && rx_ready) begin
            validNext = 1'b0;
        end
        // A consumer taking the old byte this cycle frees the register for the new one.
        if (deliver) begin
            if (!rx_valid || rx_ready) begin
                dataNext  = shiftReg;
                validNext = 1'b1;
            end else begin
                overrunNext = 1'b1;
            end
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state        <= IDLE;
            bitCnt       <= '0;
            bitIdx       <= '0;
            shiftReg     <= '0;
            rx_data      <= '0;
            rx_valid     <= 1'b0;
            rx_frame_err <= 1'b0;
            rx_overrun   <= 1'b0;
`ifdef BT_UART_RX_PARITY_EN
            parBit       <= 1'b0;
`endif
        end else begin
            state        <= stateNext;
            bitCnt       <= cntNext;
            bitIdx       <= idxNext;
            shiftReg     <= shiftNext;
            rx_data      <= dataNext;
            rx_valid     <= validNext;
            rx_frame_err <= frameErrNext;
            rx_overrun   <= overrunNext;
`ifdef BT_UART_RX_PARITY_EN
            parBit       <= parNext;
`endif
        end
    end

    assign rx_busy = (state != IDLE);

endmodule

// File: tb/tb_bt_uart_rx.sv
// Randomised, self-checking bench for bt_uart_rx against a frame-level reference model.
module tb_bt_uart_rx;

    localparam int unsigned C    = 16;
    localparam int unsigned HALF = C / 2;
`ifdef BT_UART_RX_PARITY_EN
    localparam int unsigned NBITS = 11;
`else
    localparam int unsigned NBITS = 10;
`endif
    // Two sync flops, half a bit to the start sample, then one bit per remaining frame bit, then register.
    localparam int LAT = 2 + HALF + (NBITS - 1) * C + 1;

    logic       clock;
    logic       resetn;
    logic       fpga_rxd;
    logic       bt_state;
    logic       rx_ready;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_frame_err;
    logic       rx_overrun;
    logic       rx_busy;

    int errors = 0;
    int checks = 0;
    int cycle = 0;
    int lastStart = 0;

    logic [7:0] recv[$];
    int ferrCnt = 0;
    int ovrCnt = 0;
    int validCycles = 0;
    int lastRise = -1;
    logic prevValid = 1'b0;

    bt_uart_rx #(.CLKS_PER_BIT(C)) dut (
        .clock(clock),
        .resetn(resetn),
        .fpga_rxd(fpga_rxd),
        .bt_state(bt_state),
        .rx_ready(rx_ready),
        .rx_data(rx_data),
        .rx_valid(rx_valid),
        .rx_frame_err(rx_frame_err),
        .rx_overrun(rx_overrun),
        .rx_busy(rx_busy)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        forever begin
            @(posedge clock);
            cycle++;
        end
    end

    // Observes outputs mid-cycle, after the bench has settled its inputs.
    initial begin
        forever begin
            @(negedge clock);
            #1;
            if (rx_valid && rx_ready) recv.push_back(rx_data);
            if (rx_frame_err) ferrCnt++;
            if (rx_overrun) ovrCnt++;
            if (rx_valid) validCycles++;
            if (rx_valid && !prevValid) lastRise = cycle;
            prevValid = rx_valid;
        end
    end

    task automatic waitCycles(input int n);
        repeat (n) @(negedge clock);
    endtask

    function automatic logic frameBit(input logic [7:0] b, input logic stopBit,
                                      input logic parFlip, input int i);
        if (i == 0) return 1'b0;
        if (i <= 8) return b[i-1];
`ifdef BT_UART_RX_PARITY_EN
        if (i == 9) return (^b) ^ parFlip;
`endif
        return stopBit;
    endfunction

    // dropBit >= 0 drops bt_state mid data bit dropBit until the frame ends.
    task automatic sendFrame(input logic [7:0] b, input logic stopBit, input logic parFlip,
                             input int dropBit, input int holdLow);
        @(negedge clock);
        lastStart = cycle;
        for (int i = 0; i < int'(NBITS); i++) begin
            fpga_rxd = frameBit(b, stopBit, parFlip, i);
            for (int j = 0; j < int'(C); j++) begin
                if (dropBit >= 0 && i == dropBit + 1 && j == int'(HALF)) bt_state = 1'b0;
                @(negedge clock);
            end
        end
        if (holdLow > 0) begin
            fpga_rxd = 1'b0;
            waitCycles(holdLow);
        end
        fpga_rxd = 1'b1;
        bt_state = 1'b1;
    endtask

    task automatic test_reset;
        resetn   = 1'b0;
        fpga_rxd = 1'b1;
        bt_state = 1'b1;
        rx_ready = 1'b1;
        waitCycles(3);
        checks++; if (rx_data !== 8'h00) begin errors++; $display("FAIL reset_data: got %h want 00", rx_data); end
        checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", rx_valid); end
        checks++; if (rx_frame_err !== 1'b0) begin errors++; $display("FAIL reset_ferr: got %b want 0", rx_frame_err); end
        checks++; if (rx_overrun !== 1'b0) begin errors++; $display("FAIL reset_ovr: got %b want 0", rx_overrun); end
        checks++; if (rx_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", rx_busy); end
        resetn = 1'b1;
        waitCycles(5);
    endtask

    task automatic test_basic;
        int r0 = recv.size();
        int f0 = ferrCnt;
        int v0 = validCycles;
        logic [7:0] got;
        rx_ready = 1'b1;
        sendFrame(8'hA5, 1'b1, 1'b0, -1, 0);
        waitCycles(10);
        got = (recv.size() > r0) ? recv[r0] : 8'hxx;
        checks++; if (recv.size() != r0 + 1) begin errors++; $display("FAIL basic_count: got %0d want 1", recv.size() - r0); end
        checks++; if (got !== 8'hA5) begin errors++; $display("FAIL basic_data: got %h want a5", got); end
        checks++; if (lastRise - lastStart != LAT) begin errors++; $display("FAIL basic_latency: got %0d want %0d", lastRise - lastStart, LAT); end
        checks++; if (validCycles - v0 != 1) begin errors++; $display("FAIL basic_pulse: got %0d want 1", validCycles - v0); end
        checks++; if (ferrCnt != f0) begin errors++; $display("FAIL basic_ferr: got %0d want 0", ferrCnt - f0); end
    endtask

    task automatic test_glitch;
        int r0 = recv.size();
        int f0 = ferrCnt;
        logic [7:0] got;
        @(negedge clock);
        fpga_rxd = 1'b0;
        waitCycles(4);
        fpga_rxd = 1'b1;
        waitCycles(3 * C);
        checks++; if (rx_busy !== 1'b0) begin errors++; $display("FAIL glitch_busy: got %b want 0", rx_busy); end
        checks++; if (recv.size() != r0 || ferrCnt != f0) begin errors++; $display("FAIL glitch_flags: got bytes=%0d ferr=%0d want 0 0", recv.size() - r0, ferrCnt - f0); end
        sendFrame(8'h3C, 1'b1, 1'b0, -1, 0);
        waitCycles(10);
        got = (recv.size() > r0) ? recv[r0] : 8'hxx;
        checks++; if (got !== 8'h3C || recv.size() != r0 + 1) begin errors++; $display("FAIL glitch_next: got %h want 3c", got); end
    endtask

    task automatic test_frame_err;
        int r0 = recv.size();
        int f0 = ferrCnt;
        logic [7:0] got;
        sendFrame(8'h3C, 1'b0, 1'b0, -1, 40);
        waitCycles(5);
        checks++; if (ferrCnt - f0 != 1) begin errors++; $display("FAIL ferr_count: got %0d want 1", ferrCnt - f0); end
        checks++; if (recv.size() != r0) begin errors++; $display("FAIL ferr_nobyte: got %0d want 0", recv.size() - r0); end
        sendFrame(8'h55, 1'b1, 1'b0, -1, 0);
        waitCycles(10);
        got = (recv.size() > r0) ? recv[r0] : 8'hxx;
        checks++; if (got !== 8'h55 || recv.size() != r0 + 1) begin errors++; $display("FAIL ferr_next: got %h want 55", got); end
        checks++; if (ferrCnt - f0 != 1) begin errors++; $display("FAIL ferr_total: got %0d want 1", ferrCnt - f0); end
    endtask

    task automatic test_overrun;
        int r0 = recv.size();
        int o0 = ovrCnt;
        logic [7:0] got;
        rx_ready = 1'b0;
        sendFrame(8'h11, 1'b1, 1'b0, -1, 0);
        sendFrame(8'h22, 1'b1, 1'b0, -1, 0);
        waitCycles(10);
        checks++; if (rx_valid !== 1'b1) begin errors++; $display("FAIL ovr_valid: got %b want 1", rx_valid); end
        checks++; if (rx_data !== 8'h11) begin errors++; $display("FAIL ovr_data: got %h want 11", rx_data); end
        checks++; if (ovrCnt - o0 != 1) begin errors++; $display("FAIL ovr_count: got %0d want 1", ovrCnt - o0); end
        checks++; if (recv.size() != r0) begin errors++; $display("FAIL ovr_notaken: got %0d want 0", recv.size() - r0); end
        rx_ready = 1'b1;
        @(negedge clock);
        #2;
        got = (recv.size() > r0) ? recv[r0] : 8'hxx;
        checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL ovr_clear: got %b want 0", rx_valid); end
        checks++; if (got !== 8'h11 || recv.size() != r0 + 1) begin errors++; $display("FAIL ovr_taken: got %h want 11", got); end
    endtask

    task automatic test_bt_drop;
        int r0 = recv.size();
        int f0 = ferrCnt;
        int o0 = ovrCnt;
        logic [7:0] got;
        rx_ready = 1'b1;
        sendFrame(8'h77, 1'b1, 1'b0, 3, 0);
        waitCycles(5);
        checks++; if (recv.size() != r0 || ferrCnt != f0 || ovrCnt != o0) begin errors++; $display("FAIL bt_drop: got bytes=%0d ferr=%0d ovr=%0d want 0 0 0", recv.size() - r0, ferrCnt - f0, ovrCnt - o0); end
        checks++; if (rx_busy !== 1'b0) begin errors++; $display("FAIL bt_busy: got %b want 0", rx_busy); end
        sendFrame(8'h99, 1'b1, 1'b0, -1, 0);
        waitCycles(10);
        got = (recv.size() > r0) ? recv[r0] : 8'hxx;
        checks++; if (got !== 8'h99 || recv.size() != r0 + 1) begin errors++; $display("FAIL bt_next: got %h want 99", got); end
    endtask

    task automatic test_reset_mid;
        int r0;
        int f0;
        logic [7:0] got;
        rx_ready = 1'b0;
        sendFrame(8'h5A, 1'b1, 1'b0, -1, 0);
        waitCycles(5);
        checks++; if (rx_valid !== 1'b1) begin errors++; $display("FAIL rstmid_pre_valid: got %b want 1", rx_valid); end
        fpga_rxd = 1'b0;
        waitCycles(2 + HALF + 3 * C);
        checks++; if (rx_busy !== 1'b1) begin errors++; $display("FAIL rstmid_pre_busy: got %b want 1", rx_busy); end
        resetn = 1'b0;
        #1;
        checks++; if (rx_data !== 8'h00 || rx_valid !== 1'b0) begin errors++; $display("FAIL rstmid_out: got data=%h valid=%b want 00 0", rx_data, rx_valid); end
        checks++; if (rx_busy !== 1'b0 || rx_frame_err !== 1'b0 || rx_overrun !== 1'b0) begin errors++; $display("FAIL rstmid_flags: got busy=%b ferr=%b ovr=%b want 0 0 0", rx_busy, rx_frame_err, rx_overrun); end
        fpga_rxd = 1'b1;
        waitCycles(3);
        resetn = 1'b1;
        rx_ready = 1'b1;
        waitCycles(5);
        r0 = recv.size();
        f0 = ferrCnt;
        sendFrame(8'hF0, 1'b1, 1'b0, -1, 0);
        waitCycles(10);
        got = (recv.size() > r0) ? recv[r0] : 8'hxx;
        checks++; if (got !== 8'hF0 || recv.size() != r0 + 1 || ferrCnt != f0) begin errors++; $display("FAIL rstmid_next: got %h ferr=%0d want f0 0", got, ferrCnt - f0); end
    endtask

    task automatic test_random;
        int r0 = recv.size();
        int f0 = ferrCnt;
        int expFerr = 0;
        logic [7:0] expQ[$];
        logic [7:0] b;
        logic stopOk;
        logic parFlip;
        rx_ready = 1'b1;
        for (int n = 0; n < 12; n++) begin
            b = 8'($urandom);
            stopOk = ($urandom_range(0, 3) != 0);
`ifdef BT_UART_RX_PARITY_EN
            parFlip = ($urandom_range(0, 3) == 0);
`else
            parFlip = 1'b0;
`endif
            if (stopOk && !parFlip) expQ.push_back(b);
            else expFerr++;
            sendFrame(b, stopOk, parFlip, -1, stopOk ? 0 : 20);
            waitCycles(3);
        end
        waitCycles(10);
        checks++; if (recv.size() - r0 != expQ.size()) begin errors++; $display("FAIL rand_count: got %0d want %0d", recv.size() - r0, expQ.size()); end
        checks++; if (ferrCnt - f0 != expFerr) begin errors++; $display("FAIL rand_ferr: got %0d want %0d", ferrCnt - f0, expFerr); end
        for (int i = 0; i < expQ.size(); i++) begin
            b = (recv.size() > r0 + i) ? recv[r0 + i] : 8'hxx;
            checks++; if (b !== expQ[i]) begin errors++; $display("FAIL rand_data[%0d]: got %h want %h", i, b, expQ[i]); end
        end
    endtask

`ifdef BT_UART_RX_PARITY_EN
    task automatic test_parity;
        int r0 = recv.size();
        int f0 = ferrCnt;
        rx_ready = 1'b1;
        sendFrame(8'h0F, 1'b1, 1'b1, -1, 0);
        waitCycles(10);
        checks++; if (ferrCnt - f0 != 1) begin errors++; $display("FAIL par_ferr: got %0d want 1", ferrCnt - f0); end
        checks++; if (recv.size() != r0 || rx_valid !== 1'b0) begin errors++; $display("FAIL par_nobyte: got bytes=%0d valid=%b want 0 0", recv.size() - r0, rx_valid); end
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_glitch();
        test_frame_err();
        test_overrun();
        test_bt_drop();
        test_reset_mid();
        test_random();
`ifdef BT_UART_RX_PARITY_EN
        test_parity();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
